execute_stage: RTL and testbench

//  E stage of the 5-stage MIPS pipeline: consumes D->E register outputs, selects forwarded operands, runs the ALU,

---
 rtl/execute_stage_pkg.sv | 32 +++
 rtl/execute_stage_alu.sv | 46 ++++
 rtl/execute_stage.sv | 150 +++++++++++++++
 tb/tb_execute_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the MIPS execute stage:
//   - default datapath / register-index / ALU-control widths
//   - ALU opcode encodings (ALU_AND .. ALU_SLT)
//   - operand forwarding source encodings (FWD_RF / FWD_W / FWD_M)
// No ports (package).
// -----------------------------------------------------------------------------
package execute_stage_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int RADDR_W_DEF  = 5;
    localparam int ALUCTL_W_DEF = 3;

    // ALU control encodings
    localparam logic [ALUCTL_W_DEF-1:0] ALU_AND  = 3'b000;
    localparam logic [ALUCTL_W_DEF-1:0] ALU_OR   = 3'b001;
    localparam logic [ALUCTL_W_DEF-1:0] ALU_ADD  = 3'b010;
    localparam logic [ALUCTL_W_DEF-1:0] ALU_NONE = 3'b011;
    localparam logic [ALUCTL_W_DEF-1:0] ALU_ANDN = 3'b100;
    localparam logic [ALUCTL_W_DEF-1:0] ALU_ORN  = 3'b101;
    localparam logic [ALUCTL_W_DEF-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALUCTL_W_DEF-1:0] ALU_SLT  = 3'b111;

    // Where an ALU operand comes from
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // register-file read data
        FWD_W  = 2'b01,   // write-back stage result
        FWD_M  = 2'b10    // memory stage ALU result
    } fwd_sel_t;

endpackage : execute_stage_pkg

// File: rtl/execute_stage_alu.sv
// -----------------------------------------------------------------------------
// execute_stage_alu
// Purely combinational ALU for the execute stage. Arithmetic wraps modulo
// 2^WIDTH; there is no overflow trap.
// Ports:
//   i_src_a    in  WIDTH     operand A
//   i_src_b    in  WIDTH     operand B
//   i_alu_ctl  in  ALUCTL_W  operation select
//   o_result   out WIDTH     result
// -----------------------------------------------------------------------------
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ALUCTL_W = ALUCTL_W_DEF
) (
    input  logic [WIDTH-1:0]    i_src_a,
    input  logic [WIDTH-1:0]    i_src_b,
    input  logic [ALUCTL_W-1:0] i_alu_ctl,
    output logic [WIDTH-1:0]    o_result
);

    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic                    w_lt;

    assign w_a_s = i_src_a;
    assign w_b_s = i_src_b;
    assign w_lt  = (w_a_s < w_b_s);

    always_comb begin
        o_result = '0;
        case (i_alu_ctl)
            ALU_AND:  o_result = i_src_a & i_src_b;
            ALU_OR:   o_result = i_src_a | i_src_b;
            ALU_ADD:  o_result = i_src_a + i_src_b;
            ALU_ANDN: o_result = i_src_a & ~i_src_b;
            ALU_ORN:  o_result = i_src_a | ~i_src_b;
            ALU_SUB:  o_result = i_src_a - i_src_b;
            // signed compare, result zero-extended to full width
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt};
            default:  o_result = '0;
        endcase
    end

endmodule : execute_stage_alu

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// E stage of the 5-stage MIPS pipeline. Selects forwarded operands (from its
// own M-side register, or from W via ports), runs the ALU, picks the
// destination register and registers everything into the E->M boundary.
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   FlushM                     insert a bubble into M (controls/index zeroed)
//   RegWriteE, MemtoRegE,
//   MemWriteE, ALUControlE,
//   ALUSrcE, RegDstE           control from the D->E register
//   RsE, RtE, RdE              register indices
//   SignImmE                   sign-extended immediate
//   RD1E, RD2E                 register-file read data (Rs, Rt)
//   RegWriteW, WriteRegW,
//   ResultW                    write-back stage forwarding source
//   WriteRegE                  combinational destination (hazard unit)
//   RegWriteM, MemtoRegM,
//   MemWriteM, ALUOutM,
//   WriteDataM, WriteRegM      registered E->M outputs
// -----------------------------------------------------------------------------
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter int ALUCTL_W = ALUCTL_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                FlushM,
    input  logic                RegWriteE,
    input  logic                MemtoRegE,
    input  logic                MemWriteE,
    input  logic [ALUCTL_W-1:0] ALUControlE,
    input  logic                ALUSrcE,
    input  logic                RegDstE,
    input  logic [RADDR_W-1:0]  RsE,
    input  logic [RADDR_W-1:0]  RtE,
    input  logic [RADDR_W-1:0]  RdE,
    input  logic [WIDTH-1:0]    SignImmE,
    input  logic [WIDTH-1:0]    RD1E,
    input  logic [WIDTH-1:0]    RD2E,
    input  logic                RegWriteW,
    input  logic [RADDR_W-1:0]  WriteRegW,
    input  logic [WIDTH-1:0]    ResultW,
    output logic [RADDR_W-1:0]  WriteRegE,
    output logic                RegWriteM,
    output logic                MemtoRegM,
    output logic                MemWriteM,
    output logic [WIDTH-1:0]    ALUOutM,
    output logic [WIDTH-1:0]    WriteDataM,
    output logic [RADDR_W-1:0]  WriteRegM
);

    fwd_sel_t           w_fwd_a_sel;
    fwd_sel_t           w_fwd_b_sel;
    logic [WIDTH-1:0]   w_src_a;
    logic [WIDTH-1:0]   w_write_data_e;
    logic [WIDTH-1:0]   w_src_b;
    logic [WIDTH-1:0]   w_alu_result;

    logic               r_reg_write_m;
    logic               r_mem_to_reg_m;
    logic               r_mem_write_m;
    logic [WIDTH-1:0]   r_alu_out_m;
    logic [WIDTH-1:0]   r_write_data_m;
    logic [RADDR_W-1:0] r_write_reg_m;

    // ---- E stage: forwarding, operand select, ALU ----
    // M has priority over W because it holds the younger result. Register 0
    // is hard-wired to zero, so a pending write to it must never be forwarded.
    always_comb begin
        w_fwd_a_sel = FWD_RF;
        w_fwd_b_sel = FWD_RF;
        if (r_reg_write_m && (r_write_reg_m != '0) && (r_write_reg_m == RsE))
            w_fwd_a_sel = FWD_M;
        else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == RsE))
            w_fwd_a_sel = FWD_W;
        if (r_reg_write_m && (r_write_reg_m != '0) && (r_write_reg_m == RtE))
            w_fwd_b_sel = FWD_M;
        else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == RtE))
            w_fwd_b_sel = FWD_W;
    end

    always_comb begin
        w_src_a = RD1E;
        case (w_fwd_a_sel)
            FWD_M:   w_src_a = r_alu_out_m;
            FWD_W:   w_src_a = ResultW;
            default: w_src_a = RD1E;
        endcase
    end

    always_comb begin
        w_write_data_e = RD2E;
        case (w_fwd_b_sel)
            FWD_M:   w_write_data_e = r_alu_out_m;
            FWD_W:   w_write_data_e = ResultW;
            default: w_write_data_e = RD2E;
        endcase
    end

    assign w_src_b   = ALUSrcE ? SignImmE : w_write_data_e;
    assign WriteRegE = RegDstE ? RdE : RtE;

    execute_stage_alu #(
        .WIDTH    (WIDTH),
        .ALUCTL_W (ALUCTL_W)
    ) u_alu (
        .i_src_a   (w_src_a),
        .i_src_b   (w_src_b),
        .i_alu_ctl (ALUControlE),
        .o_result  (w_alu_result)
    );

    // ---- E -> M boundary ----
    // A flush kills the instruction's side effects (controls and destination)
    // but leaves the data registers holding their previous contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_write_reg_m  <= '0;
            r_alu_out_m    <= '0;
            r_write_data_m <= '0;
        end else if (FlushM) begin
            r_reg_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_write_reg_m  <= '0;
        end else begin
            r_reg_write_m  <= RegWriteE;
            r_mem_to_reg_m <= MemtoRegE;
            r_mem_write_m  <= MemWriteE;
            r_write_reg_m  <= WriteRegE;
            r_alu_out_m    <= w_alu_result;
            r_write_data_m <= w_write_data_e;
        end
    end

    assign RegWriteM  = r_reg_write_m;
    assign MemtoRegM  = r_mem_to_reg_m;
    assign MemWriteM  = r_mem_write_m;
    assign ALUOutM    = r_alu_out_m;
    assign WriteDataM = r_write_data_m;
    assign WriteRegM  = r_write_reg_m;

endmodule : execute_stage

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
// Directed-vector bench for execute_stage with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic        FlushM;
    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE, RegDstE;
    logic [4:0]  RsE, RtE, RdE;
    logic [31:0] SignImmE, RD1E, RD2E;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [4:0]  WriteRegE;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;

    int n_vec = 0;
    int n_err = 0;

    execute_stage dut (
        .clk         (clk),
        .reset       (reset),
        .FlushM      (FlushM),
        .RegWriteE   (RegWriteE),
        .MemtoRegE   (MemtoRegE),
        .MemWriteE   (MemWriteE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RegDstE     (RegDstE),
        .RsE         (RsE),
        .RtE         (RtE),
        .RdE         (RdE),
        .SignImmE    (SignImmE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .RegWriteW   (RegWriteW),
        .WriteRegW   (WriteRegW),
        .ResultW     (ResultW),
        .WriteRegE   (WriteRegE),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .ALUOutM     (ALUOutM),
        .WriteDataM  (WriteDataM),
        .WriteRegM   (WriteRegM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_e();
        FlushM      = 1'b0;
        RegWriteE   = 1'b0;
        MemtoRegE   = 1'b0;
        MemWriteE   = 1'b0;
        ALUControlE = 3'b010;
        ALUSrcE     = 1'b0;
        RegDstE     = 1'b0;
        RsE         = 5'd0;
        RtE         = 5'd0;
        RdE         = 5'd0;
        SignImmE    = 32'd0;
        RD1E        = 32'd0;
        RD2E        = 32'd0;
        RegWriteW   = 1'b0;
        WriteRegW   = 5'd0;
        ResultW     = 32'd0;
    endtask

    // advance one edge and sample away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, 32'd0);
        chk({tag, ".MemtoRegM"},  {31'd0, MemtoRegM}, 32'd0);
        chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, 32'd0);
        chk({tag, ".WriteRegM"},  {27'd0, WriteRegM}, 32'd0);
        chk({tag, ".ALUOutM"},    ALUOutM,            32'd0);
        chk({tag, ".WriteDataM"}, WriteDataM,         32'd0);
    endtask

    // ALU operation table: a, b, ctl, expected
    logic [31:0] op_a   [8];
    logic [31:0] op_b   [8];
    logic [2:0]  op_ctl [8];
    logic [31:0] op_exp [8];

    initial begin
        op_a[0] = 32'hF0F0_00FF; op_b[0] = 32'h0FF0_0F0F; op_ctl[0] = 3'b000; op_exp[0] = 32'h00F0_000F;
        op_a[1] = 32'hF0F0_00FF; op_b[1] = 32'h0FF0_0F0F; op_ctl[1] = 3'b001; op_exp[1] = 32'hFFF0_0FFF;
        op_a[2] = 32'hF0F0_00FF; op_b[2] = 32'h0FF0_0F0F; op_ctl[2] = 3'b100; op_exp[2] = 32'hF000_00F0;
        op_a[3] = 32'hF0F0_00FF; op_b[3] = 32'h0FF0_0F0F; op_ctl[3] = 3'b101; op_exp[3] = 32'hF0FF_F0FF;
        op_a[4] = 32'hF0F0_00FF; op_b[4] = 32'h0FF0_0F0F; op_ctl[4] = 3'b011; op_exp[4] = 32'h0000_0000;
        op_a[5] = 32'h0000_0001; op_b[5] = 32'hFFFF_FFFF; op_ctl[5] = 3'b111; op_exp[5] = 32'h0000_0000;
        op_a[6] = 32'hFFFF_FFFF; op_b[6] = 32'h0000_0001; op_ctl[6] = 3'b010; op_exp[6] = 32'h0000_0000;
        op_a[7] = 32'h0000_0005; op_b[7] = 32'h0000_0003; op_ctl[7] = 3'b111; op_exp[7] = 32'h0000_0000;
    end

    initial begin
        clear_e();
        reset = 1'b1;

        // 1: reset with nonzero inputs for two edges
        RegWriteE = 1'b1; MemtoRegE = 1'b1; MemWriteE = 1'b1;
        RD1E = 32'd10; RD2E = 32'd3; RtE = 5'd6; RsE = 5'd1;
        step();
        step();
        chk_m_zero("reset");
        reset = 1'b0;
        step();
        chk("rel.ALUOutM",    ALUOutM,            32'd13);
        chk("rel.WriteDataM", WriteDataM,         32'd3);
        chk("rel.WriteRegM",  {27'd0, WriteRegM}, 32'd6);
        chk("rel.RegWriteM",  {31'd0, RegWriteM}, 32'd1);
        chk("rel.MemtoRegM",  {31'd0, MemtoRegM}, 32'd1);
        chk("rel.MemWriteM",  {31'd0, MemWriteM}, 32'd1);

        // 2: ADD with RegDst selecting Rd
        clear_e();
        RD1E = 32'd5; RD2E = 32'd7; RsE = 5'd1; RtE = 5'd2; RdE = 5'd3; RegDstE = 1'b1;
        #1;
        chk("add.WriteRegE", {27'd0, WriteRegE}, 32'd3);
        RegDstE = 1'b0;
        #1;
        chk("rt.WriteRegE", {27'd0, WriteRegE}, 32'd2);
        RegDstE = 1'b1;
        step();
        chk("add.ALUOutM",   ALUOutM,            32'd12);
        chk("add.WriteRegM", {27'd0, WriteRegM}, 32'd3);

        // 3: SLT signed and SUB wrap
        clear_e();
        RsE = 5'd8; RtE = 5'd9;
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b111;
        step();
        chk("slt.ALUOutM", ALUOutM, 32'd1);
        RD1E = 32'd0; RD2E = 32'd1; ALUControlE = 3'b110;
        step();
        chk("sub.ALUOutM", ALUOutM, 32'hFFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            RD1E = op_a[i]; RD2E = op_b[i]; ALUControlE = op_ctl[i];
            step();
            chk($sformatf("alu%0d.ALUOutM", i), ALUOutM, op_exp[i]);
        end

        // ALUSrcE picks the immediate
        RD1E = 32'd100; RD2E = 32'd1; SignImmE = 32'hFFFF_FFFE; ALUControlE = 3'b010; ALUSrcE = 1'b1;
        step();
        chk("imm.ALUOutM",    ALUOutM,    32'd98);
        chk("imm.WriteDataM", WriteDataM, 32'd1);

        // 4: forwarding priority M over W
        clear_e();
        RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'd99;
        RegWriteE = 1'b1; RegDstE = 1'b1; RdE = 5'd4; RsE = 5'd10; RtE = 5'd11;
        RD1E = 32'd20; RD2E = 32'd0;
        step();
        chk("fw.setup", ALUOutM, 32'd20);
        RegWriteE = 1'b0; RdE = 5'd12; RsE = 5'd4; RtE = 5'd12; RD1E = 32'd1; RD2E = 32'd0;
        step();
        chk("fwdM.srcA", ALUOutM, 32'd20);
        // M no longer writes: W supplies r4 for both operands
        RsE = 5'd4; RtE = 5'd4; RD1E = 32'd1; RD2E = 32'd5; ALUSrcE = 1'b1; SignImmE = 32'd0;
        step();
        chk("fwdW.srcA",       ALUOutM,    32'd99);
        chk("fwdW.WriteDataM", WriteDataM, 32'd99);
        RegWriteW = 1'b0; RD1E = 32'd1; RD2E = 32'd5;
        step();
        chk("rf.srcA",       ALUOutM,    32'd1);
        chk("rf.WriteDataM", WriteDataM, 32'd5);

        // 5: register 0 is never forwarded
        clear_e();
        RegWriteE = 1'b1; RegDstE = 1'b0; RtE = 5'd0; RsE = 5'd13;
        RD1E = 32'h55; ALUSrcE = 1'b1; SignImmE = 32'd0;
        step();
        chk("r0.setupReg", {27'd0, WriteRegM}, 32'd0);
        chk("r0.setupOut", ALUOutM, 32'h55);
        RegWriteE = 1'b0; RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'd77;
        RsE = 5'd0; RD1E = 32'd0; RtE = 5'd0; RD2E = 32'd0; ALUSrcE = 1'b0;
        step();
        chk("r0.srcA",       ALUOutM,    32'd0);
        chk("r0.WriteDataM", WriteDataM, 32'd0);

        // 6: FlushM bubbles controls, holds data
        clear_e();
        RegWriteE = 1'b1; MemWriteE = 1'b1; MemtoRegE = 1'b1; RegDstE = 1'b1; RdE = 5'd7;
        RsE = 5'd14; RtE = 5'd13; RD1E = 32'h1234; RD2E = 32'hAB; ALUSrcE = 1'b1;
        step();
        chk("fl.setupOut",  ALUOutM,    32'h1234);
        chk("fl.setupData", WriteDataM, 32'hAB);
        RsE = 5'd14; RtE = 5'd15; RD1E = 32'h9999; RD2E = 32'h77; FlushM = 1'b1;
        step();
        chk("flush.RegWriteM",  {31'd0, RegWriteM}, 32'd0);
        chk("flush.MemWriteM",  {31'd0, MemWriteM}, 32'd0);
        chk("flush.MemtoRegM",  {31'd0, MemtoRegM}, 32'd0);
        chk("flush.WriteRegM",  {27'd0, WriteRegM}, 32'd0);
        chk("flush.ALUOutM",    ALUOutM,            32'h1234);
        chk("flush.WriteDataM", WriteDataM,         32'hAB);
        reset = 1'b1;
        step();
        chk_m_zero("rstflush");
        reset = 1'b0;
        FlushM = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_execute_stage
